// File: rtl/serial_add_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : serial_add_ctrl
// Description : Bit-serial adder/subtractor controller. Operands are captured
//               on an accepted start, then added (or subtracted) LSB first
//               through a single full-adder bit slice, one bit per clock.
//               Carry-out and signed overflow are latched with the result.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             op_sub,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum_out,
    output logic             c_out,
    output logic             ovf
);

    // One extra counter bit so the count can reach WIDTH without wrapping.
    localparam int CNT_W = $clog2(WIDTH) + 1;

    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_run  = 2'd1;
    localparam logic [1:0] c_st_done = 2'd2;

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_sub;
    logic             r_carry;
    logic [CNT_W-1:0] r_cnt;

    logic w_b_bit;
    logic w_sum;
    logic w_carry;

    // Single-bit full adder; B is inverted for subtraction (A + ~B + 1, the +1
    // comes from the carry register being preloaded with op_sub).
    always_comb begin
        w_b_bit = r_b[0] ^ r_sub;
        w_sum   = r_a[0] ^ w_b_bit ^ r_carry;
        w_carry = (r_a[0] & w_b_bit) | (r_a[0] & r_carry) | (w_b_bit & r_carry);
    end

    // Control FSM and serial datapath; all outputs are registered here.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_st_idle;
            r_a     <= '0;
            r_b     <= '0;
            r_sub   <= 1'b0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            sum_out <= '0;
            c_out   <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    done <= 1'b0;
                    if (start) begin
                        r_a     <= in_a;
                        r_b     <= in_b;
                        r_sub   <= op_sub;
                        r_carry <= op_sub;
                        r_cnt   <= '0;
                        busy    <= 1'b1;
                        r_state <= c_st_run;
                    end
                end
                c_st_run: begin
                    // Result fills from the MSB side so bit 0 lands at sum_out[0]
                    // after WIDTH shifts.
                    sum_out <= {w_sum, sum_out[WIDTH-1:1]};
                    r_a     <= {1'b0, r_a[WIDTH-1:1]};
                    r_b     <= {1'b0, r_b[WIDTH-1:1]};
                    r_carry <= w_carry;
                    r_cnt   <= r_cnt + c_cnt_one;
                    if (r_cnt == c_cnt_last) begin
                        // r_carry is the carry into the MSB at this point.
                        c_out   <= w_carry;
                        ovf     <= r_carry ^ w_carry;
                        done    <= 1'b1;
                        r_state <= c_st_done;
                    end
                end
                c_st_done: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    r_state <= c_st_idle;
                end
                default: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_serial_add_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_add_ctrl
// Description : Self-checking bench for serial_add_ctrl. Directed and random
//               operations are checked against an integer-arithmetic model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_add_ctrl;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic         start;
    logic         op_sub;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         busy;
    logic         done;
    logic [W-1:0] sum_out;
    logic         c_out;
    logic         ovf;

    int n_cmp  = 0;
    int n_fail = 0;

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .op_sub  (op_sub),
        .in_a    (in_a),
        .in_b    (in_b),
        .busy    (busy),
        .done    (done),
        .sum_out (sum_out),
        .c_out   (c_out),
        .ovf     (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain integer arithmetic; returns {ovf, c_out, sum}.
    function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic sub);
        int ua, ub, sa, sb, r, rs;
        logic [W-1:0] s;
        logic c, o;
        ua = int'(a);
        ub = int'(b);
        sa = int'($signed(a));
        sb = int'($signed(b));
        r  = sub ? (ua - ub) : (ua + ub);
        rs = sub ? (sa - sb) : (sa + sb);
        s  = W'(r);
        c  = sub ? (ua >= ub) : (r >= (1 << W));
        o  = (rs > (2 ** (W - 1)) - 1) || (rs < -(2 ** (W - 1)));
        return {o, c, s};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One complete operation: checks latency, busy length, single done pulse,
    // results at done and held afterwards. Inputs are scrambled while busy.
    task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic sub, input bit mid_start);
        logic [W+1:0] e;
        int busy_cnt, done_cnt, done_at;
        e = model(a, b, sub);
        busy_cnt = 0;
        done_cnt = 0;
        done_at  = -1;
        in_a   = a;
        in_b   = b;
        op_sub = sub;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        for (int i = 0; i < W + 4; i++) begin
            if (busy === 1'b1) busy_cnt++;
            if (done === 1'b1) begin
                done_cnt++;
                done_at = i;
                check({tag, " sum@done"}, 32'(sum_out), 32'(e[W-1:0]));
                check({tag, " c@done"},   32'(c_out),   32'(e[W]));
                check({tag, " ovf@done"}, 32'(ovf),     32'(e[W+1]));
            end
            in_a   = W'($urandom);
            in_b   = W'($urandom);
            op_sub = 1'($urandom);
            start  = mid_start && (i == 3);
            tick();
        end
        start = 1'b0;
        check({tag, " done_cnt"}, 32'(done_cnt), 32'd1);
        check({tag, " done_at"},  32'(done_at),  32'(W));
        check({tag, " busy_len"}, 32'(busy_cnt), 32'(W + 1));
        check({tag, " sum_hold"}, 32'(sum_out),  32'(e[W-1:0]));
        check({tag, " c_hold"},   32'(c_out),    32'(e[W]));
        check({tag, " ovf_hold"}, 32'(ovf),      32'(e[W+1]));
    endtask

    initial begin
        logic [W+1:0] q[$];
        logic [W+1:0] e;
        logic         prev_done;
        bit           exp_done;
        int           per;

        rst = 1'b1; start = 1'b0; op_sub = 1'b0; in_a = '0; in_b = '0;
        tick();
        tick();
        check("rst busy", 32'(busy),    32'd0);
        check("rst done", 32'(done),    32'd0);
        check("rst sum",  32'(sum_out), 32'd0);
        check("rst c",    32'(c_out),   32'd0);
        check("rst ovf",  32'(ovf),     32'd0);
        rst = 1'b0;
        tick();

        // Directed vectors with hand-computed expectations.
        run_op("add2D14", 8'h2D, 8'h14, 1'b0, 1'b0);
        check("add2D14 sum", 32'(sum_out), 32'h41);
        check("add2D14 c",   32'(c_out),   32'd0);
        run_op("addFF01", 8'hFF, 8'h01, 1'b0, 1'b0);
        check("addFF01 sum", 32'(sum_out), 32'h00);
        check("addFF01 c",   32'(c_out),   32'd1);
        run_op("add7F01", 8'h7F, 8'h01, 1'b0, 1'b0);
        check("add7F01 sum", 32'(sum_out), 32'h80);
        check("add7F01 ovf", 32'(ovf),     32'd1);
        run_op("sub0507", 8'h05, 8'h07, 1'b1, 1'b0);
        check("sub0507 sum", 32'(sum_out), 32'hFE);
        check("sub0507 c",   32'(c_out),   32'd0);
        run_op("sub8001", 8'h80, 8'h01, 1'b1, 1'b0);
        check("sub8001 sum", 32'(sum_out), 32'h7F);
        check("sub8001 ovf", 32'(ovf),     32'd1);

        // Start asserted while busy must be ignored.
        run_op("busy_start", 8'h33, 8'h5A, 1'b0, 1'b1);

        // Random operations.
        for (int k = 0; k < 20; k++)
            run_op("rand", W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));

        // Reset in the middle of an operation.
        in_a = 8'hAA; in_b = 8'h55; op_sub = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort busy", 32'(busy),    32'd0);
        check("abort done", 32'(done),    32'd0);
        check("abort sum",  32'(sum_out), 32'd0);
        check("abort c",    32'(c_out),   32'd0);
        check("abort ovf",  32'(ovf),     32'd0);
        for (int i = 0; i < W + 3; i++) begin
            check("abort no_done", 32'(done), 32'd0);
            tick();
        end
        run_op("post_abort", 8'hC3, 8'h3C, 1'b1, 1'b0);

        // Reset and start together: start is dropped.
        rst = 1'b1; start = 1'b1;
        tick();
        rst = 1'b0; start = 1'b0;
        tick();
        check("rst+start busy", 32'(busy), 32'd0);

        // Start held high: an operation every W+2 cycles.
        per = W + 2;
        prev_done = 1'b0;
        start = 1'b1;
        for (int ed = 0; ed <= 3 * per + W; ed++) begin
            in_a   = W'($urandom);
            in_b   = W'($urandom);
            op_sub = 1'($urandom);
            start  = (ed <= 3 * per);
            if (start && (ed % per == 0)) q.push_back(model(in_a, in_b, op_sub));
            tick();
            exp_done = (ed >= W) && ((ed - W) % per == 0);
            check("b2b done", 32'(done), 32'(exp_done));
            if (done === 1'b1) begin
                check("b2b no_consec", 32'(prev_done), 32'd0);
                if (q.size() > 0) begin
                    e = q.pop_front();
                    check("b2b sum", 32'(sum_out), 32'(e[W-1:0]));
                    check("b2b c",   32'(c_out),   32'(e[W]));
                    check("b2b ovf", 32'(ovf),     32'(e[W+1]));
                end else begin
                    check("b2b extra_done", 32'd1, 32'd0);
                end
            end
            prev_done = done;
        end
        start = 1'b0;
        check("b2b left", 32'(q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
